// File: rtl/reg_two_reader.sv
// Single-writer register with two independent readers, each tracking
// fresh data plus a sticky overrun flag and a saturating overrun counter.
module reg_two_reader_rd #(
    parameter int cntw = 8
) (
    input  logic            CLK,
    input  logic            RST_N,
    input  logic            EN,
    input  logic            DEQ,
    input  logic            CLR_OVR,
    output logic            RDY,
    output logic            OVR,
    output logic [cntw-1:0] OVR_CNT
);

    logic            r_rdy;
    logic            r_ovr;
    logic [cntw-1:0] r_cnt;
    logic            w_ovr_evt;
    logic            w_sat;
    logic [cntw-1:0] w_cnt_inc;

    // A write landing on an unconsumed value is an overrun unless the
    // reader dequeues that old value in the same cycle.
    assign w_ovr_evt = EN & r_rdy & ~DEQ;
    assign w_sat     = &r_cnt;
    assign w_cnt_inc = w_sat ? r_cnt : r_cnt + cntw'(1);

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_rdy <= 1'b0;
        end else if (EN) begin
            r_rdy <= 1'b1;
        end else if (DEQ) begin
            r_rdy <= 1'b0;
        end
    end

    // The overrun event takes priority over a simultaneous clear.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_ovr <= 1'b0;
            r_cnt <= '0;
        end else if (w_ovr_evt) begin
            r_ovr <= 1'b1;
            r_cnt <= CLR_OVR ? cntw'(1) : w_cnt_inc;
        end else if (CLR_OVR) begin
            r_ovr <= 1'b0;
            r_cnt <= '0;
        end
    end

    assign RDY     = r_rdy;
    assign OVR     = r_ovr;
    assign OVR_CNT = r_cnt;

endmodule

module reg_two_reader #(
    parameter int               width = 1,
    parameter logic [width-1:0] init  = {width{1'b0}},
    parameter int               cntw  = 8
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic [width-1:0] D_IN,
    input  logic             EN,
    output logic [width-1:0] Q_OUT,
    output logic             RDY_A,
    output logic             RDY_B,
    input  logic             DEQ_A,
    input  logic             DEQ_B,
    output logic             OVR_A,
    output logic             OVR_B,
    output logic [cntw-1:0]  OVR_CNT_A,
    output logic [cntw-1:0]  OVR_CNT_B,
    input  logic             CLR_OVR
);

    logic [width-1:0] r_q;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_q <= init;
        end else if (EN) begin
            r_q <= D_IN;
        end
    end

    assign Q_OUT = r_q;

    reg_two_reader_rd #(.cntw(cntw)) u_rd_a (
        .CLK     (CLK),
        .RST_N   (RST_N),
        .EN      (EN),
        .DEQ     (DEQ_A),
        .CLR_OVR (CLR_OVR),
        .RDY     (RDY_A),
        .OVR     (OVR_A),
        .OVR_CNT (OVR_CNT_A)
    );

    reg_two_reader_rd #(.cntw(cntw)) u_rd_b (
        .CLK     (CLK),
        .RST_N   (RST_N),
        .EN      (EN),
        .DEQ     (DEQ_B),
        .CLR_OVR (CLR_OVR),
        .RDY     (RDY_B),
        .OVR     (OVR_B),
        .OVR_CNT (OVR_CNT_B)
    );

endmodule

// File: tb/tb_reg_two_reader.sv
// Bench for reg_two_reader: directed scenarios plus random traffic
// against a behavioural model, on an 8-bit and a 2-bit counter build.
module tb_reg_two_reader;

    logic       CLK;
    logic       RST_N;
    logic [7:0] D_IN;
    logic       EN;
    logic       DEQ_A;
    logic       DEQ_B;
    logic       CLR_OVR;

    logic [7:0] q1, q2;
    logic       ra1, rb1, oa1, ob1;
    logic       ra2, rb2, oa2, ob2;
    logic [7:0] ca1, cb1;
    logic [1:0] ca2, cb2;

    int total;
    int bad;

    // behavioural model: unbounded counts, saturation applied on compare
    logic [7:0] m_q;
    bit         m_fa, m_fb, m_oa, m_ob;
    int         m_ca, m_cb;

    reg_two_reader #(.width(8), .init(8'h5A), .cntw(8)) dut1 (
        .CLK(CLK), .RST_N(RST_N), .D_IN(D_IN), .EN(EN), .Q_OUT(q1),
        .RDY_A(ra1), .RDY_B(rb1), .DEQ_A(DEQ_A), .DEQ_B(DEQ_B),
        .OVR_A(oa1), .OVR_B(ob1), .OVR_CNT_A(ca1), .OVR_CNT_B(cb1),
        .CLR_OVR(CLR_OVR)
    );

    reg_two_reader #(.width(8), .init(8'h5A), .cntw(2)) dut2 (
        .CLK(CLK), .RST_N(RST_N), .D_IN(D_IN), .EN(EN), .Q_OUT(q2),
        .RDY_A(ra2), .RDY_B(rb2), .DEQ_A(DEQ_A), .DEQ_B(DEQ_B),
        .OVR_A(oa2), .OVR_B(ob2), .OVR_CNT_A(ca2), .OVR_CNT_B(cb2),
        .CLR_OVR(CLR_OVR)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    function automatic int sat(input int c, input int mx);
        return (c > mx) ? mx : c;
    endfunction

    function automatic logic [27:0] exp1();
        return {m_q, m_fa, m_fb, m_oa, m_ob,
                8'(sat(m_ca, 255)), 8'(sat(m_cb, 255))};
    endfunction

    function automatic logic [15:0] exp2();
        return {m_q, m_fa, m_fb, m_oa, m_ob,
                2'(sat(m_ca, 3)), 2'(sat(m_cb, 3))};
    endfunction

    function automatic logic [27:0] act1();
        return {q1, ra1, rb1, oa1, ob1, ca1, cb1};
    endfunction

    function automatic logic [15:0] act2();
        return {q2, ra2, rb2, oa2, ob2, ca2, cb2};
    endfunction

    task automatic model_reset();
        m_q = 8'h5A;
        m_fa = 0; m_fb = 0; m_oa = 0; m_ob = 0;
        m_ca = 0; m_cb = 0;
    endtask

    // one clock: drive at negedge, model the edge, return at next negedge
    task automatic step(input bit en, input logic [7:0] d,
                        input bit da, input bit db, input bit clr);
        bit ev_a, ev_b;
        EN = en; D_IN = d; DEQ_A = da; DEQ_B = db; CLR_OVR = clr;
        @(posedge CLK);
        if (RST_N) begin
            ev_a = en && m_fa && !da;
            ev_b = en && m_fb && !db;
            if (ev_a) begin
                m_oa = 1; m_ca = clr ? 1 : m_ca + 1;
            end else if (clr) begin
                m_oa = 0; m_ca = 0;
            end
            if (ev_b) begin
                m_ob = 1; m_cb = clr ? 1 : m_cb + 1;
            end else if (clr) begin
                m_ob = 0; m_cb = 0;
            end
            if (en) begin
                m_q = d; m_fa = 1; m_fb = 1;
            end else begin
                if (da) m_fa = 0;
                if (db) m_fb = 0;
            end
        end
        @(negedge CLK);
        EN = 0; DEQ_A = 0; DEQ_B = 0; CLR_OVR = 0;
    endtask

    task automatic test_reset();
        RST_N = 0; EN = 1; D_IN = 8'hFF; DEQ_A = 1; DEQ_B = 1; CLR_OVR = 0;
        model_reset();
        repeat (2) @(negedge CLK);
        total++;
        if (act1() !== {8'h5A, 4'b0, 16'h0}) begin
            $display("FAIL reset_hold1 got=%h want=%h",
                     act1(), {8'h5A, 4'b0, 16'h0});
            bad++;
        end
        total++;
        if (act2() !== {8'h5A, 8'h0}) begin
            $display("FAIL reset_hold2 got=%h want=%h",
                     act2(), {8'h5A, 8'h0});
            bad++;
        end
        EN = 0; DEQ_A = 0; DEQ_B = 0;
        RST_N = 1;
        @(negedge CLK);
        for (int i = 0; i < 3; i++) begin
            step(0, 8'h00, 1, 1, 0);
            total++;
            if (act1() !== {8'h5A, 4'b0, 16'h0}) begin
                $display("FAIL idle_deq%0d got=%h want=%h",
                         i, act1(), {8'h5A, 4'b0, 16'h0});
                bad++;
            end
        end
    endtask

    task automatic test_staggered();
        step(1, 8'h3C, 0, 0, 0);
        total++;
        if (q1 !== 8'h3C || ra1 !== 1 || rb1 !== 1) begin
            $display("FAIL write_3c got=%h/%b%b want=3c/11", q1, ra1, rb1);
            bad++;
        end
        step(0, 8'h00, 1, 0, 0);
        total++;
        if (ra1 !== 0 || rb1 !== 1) begin
            $display("FAIL deq_a got=%b%b want=01", ra1, rb1);
            bad++;
        end
        step(0, 8'h00, 0, 0, 0);
        step(0, 8'h00, 0, 1, 0);
        total++;
        if (act1() !== exp1() || rb1 !== 0 || oa1 !== 0 || ob1 !== 0) begin
            $display("FAIL deq_b got=%h want=%h", act1(), exp1());
            bad++;
        end
    endtask

    task automatic test_overrun();
        for (int i = 1; i <= 5; i++) step(1, 8'(i), 0, 1, 0);
        total++;
        if (q1 !== 8'h05 || oa1 !== 1 || ca1 !== 8'd4 ||
            ob1 !== 0 || cb1 !== 8'd0) begin
            $display("FAIL ovr_cnt got=%h/%b/%0d/%b/%0d want=05/1/4/0/0",
                     q1, oa1, ca1, ob1, cb1);
            bad++;
        end
        total++;
        if (act2() !== exp2() || ca2 !== 2'd3) begin
            $display("FAIL ovr_cnt2 got=%h want=%h", act2(), exp2());
            bad++;
        end
    endtask

    task automatic test_write_deq();
        step(1, 8'h77, 1, 1, 0);
        total++;
        if (ra1 !== 1 || ca1 !== 8'd4 || q1 !== 8'h77) begin
            $display("FAIL wr_deq got=%b/%0d/%h want=1/4/77", ra1, ca1, q1);
            bad++;
        end
    endtask

    task automatic test_saturate_clear();
        step(0, 8'h00, 0, 0, 1);
        for (int i = 0; i < 6; i++) step(1, 8'($urandom), 0, 0, 0);
        total++;
        if (ca2 !== 2'd3 || oa2 !== 1 || ca1 !== 8'd6) begin
            $display("FAIL saturate got=%0d/%b/%0d want=3/1/6",
                     ca2, oa2, ca1);
            bad++;
        end
        step(0, 8'h00, 0, 0, 1);
        total++;
        if (ca2 !== 0 || oa2 !== 0 || ca1 !== 0 || oa1 !== 0 || ra1 !== 1) begin
            $display("FAIL clear got=%0d/%b/%0d/%b/%b want=0/0/0/0/1",
                     ca2, oa2, ca1, oa1, ra1);
            bad++;
        end
        step(1, 8'h9E, 0, 0, 1);
        total++;
        if (ca2 !== 2'd1 || oa2 !== 1 || ca1 !== 8'd1 || oa1 !== 1) begin
            $display("FAIL clr_evt got=%0d/%b/%0d/%b want=1/1/1/1",
                     ca2, oa2, ca1, oa1);
            bad++;
        end
        total++;
        if (act1() !== exp1()) begin
            $display("FAIL clr_model got=%h want=%h", act1(), exp1());
            bad++;
        end
    endtask

    task automatic test_async_reset();
        step(0, 8'h00, 1, 1, 1);
        step(1, 8'hA1, 0, 0, 0);
        step(1, 8'hA2, 1, 0, 0);
        step(1, 8'hA3, 1, 0, 0);
        total++;
        if (ra1 !== 1 || cb1 !== 8'd2) begin
            $display("FAIL pre_rst got=%b/%0d want=1/2", ra1, cb1);
            bad++;
        end
        #2 RST_N = 0;
        #1;
        model_reset();
        total++;
        if (act1() !== {8'h5A, 4'b0, 16'h0} || act2() !== {8'h5A, 8'h0}) begin
            $display("FAIL async_rst got=%h/%h want=5a00000/5a00",
                     act1(), act2());
            bad++;
        end
        @(negedge CLK);
        RST_N = 1;
        @(negedge CLK);
    endtask

    task automatic test_random();
        bit en, da, db, clr;
        for (int i = 0; i < 400; i++) begin
            en  = ($urandom_range(0, 1) == 1);
            da  = ($urandom_range(0, 2) == 0);
            db  = ($urandom_range(0, 1) == 1);
            clr = ($urandom_range(0, 15) == 0);
            step(en, 8'($urandom), da, db, clr);
            total++;
            if (act1() !== exp1()) begin
                $display("FAIL rand1[%0d] got=%h want=%h", i, act1(), exp1());
                bad++;
            end
            total++;
            if (act2() !== exp2()) begin
                $display("FAIL rand2[%0d] got=%h want=%h", i, act2(), exp2());
                bad++;
            end
        end
    endtask

    initial begin
        total = 0;
        bad = 0;
        D_IN = 8'h00;
        test_reset();
        test_staggered();
        test_overrun();
        test_write_deq();
        test_saturate_clear();
        test_async_reset();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
